// File: rtl/nn_pingpong_buffer.sv
// nn_pingpong_buffer
// Double-buffered activation memory between two matrix-multiply stages.
// The producer fills the write bank while the consumer reads the read bank.
// A swap exchanges the two banks in one cycle. A clear sequencer zeroes the
// write bank, one word per cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   wr_en     write request into the write bank (wr_addr, wr_data)
//   rd_en     read request from the read bank (rd_addr)
//   rd_data   registered read data, valid when rd_valid=1
//   rd_valid  one-cycle strobe: rd_data was updated this cycle
//   swap      exchange read and write banks
//   clear     start zeroing the write bank
//   busy      clear sequence in progress
//   wr_full   DEPTH writes have been accepted since the last swap or clear
//   rd_bank   index of the read bank; the write bank is ~rd_bank
//   addr_err  sticky out-of-range flag, cleared by reset or a completed clear
module nn_pingpong_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     swap,
  input  logic                     clear,
  output logic                     busy,
  output logic                     wr_full,
  output logic                     rd_bank,
  output logic                     addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t                     r_state;
  logic [IDX_W-1:0]           r_clr_ptr;
  logic [CNT_W-1:0]           r_wr_cnt;
  logic                       r_wr_full;
  logic                       r_busy;
  logic                       r_rd_bank;
  logic                       r_addr_err;
  logic signed [DATA_W-1:0]   r_rd_data;
  logic                       r_rd_valid;

  // Storage; contents are intentionally not reset.
  logic signed [DATA_W-1:0]   r_bank0 [DEPTH];
  logic signed [DATA_W-1:0]   r_bank1 [DEPTH];

  logic                       w_clearing;
  logic                       w_cmd_ok;
  logic                       w_wr_in;
  logic                       w_rd_in;
  logic [IDX_W-1:0]           w_wr_idx;
  logic [IDX_W-1:0]           w_rd_idx;
  logic                       w_wr_acc;
  logic                       w_mem_we;
  logic [IDX_W-1:0]           w_mem_idx;
  logic signed [DATA_W-1:0]   w_mem_wdata;
  logic signed [DATA_W-1:0]   w_rd_word;

  assign w_clearing = (r_state == S_CLEAR);
  // Normal operations are taken only in IDLE and only when clear is not
  // being requested in the same cycle.
  assign w_cmd_ok   = (r_state == S_IDLE) && !clear;

  assign w_wr_in    = ({1'b0, wr_addr} < DEPTH_A);
  assign w_rd_in    = ({1'b0, rd_addr} < DEPTH_A);
  assign w_wr_idx   = wr_addr[IDX_W-1:0];
  assign w_rd_idx   = rd_addr[IDX_W-1:0];
  assign w_wr_acc   = w_cmd_ok && wr_en && w_wr_in;

  // The clear sequencer and the producer share the single write port.
  assign w_mem_we    = !reset && (w_wr_acc || w_clearing);
  assign w_mem_idx   = w_clearing ? r_clr_ptr : w_wr_idx;
  assign w_mem_wdata = w_clearing ? '0 : wr_data;

  assign w_rd_word   = r_rd_bank ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];

  // Write bank is ~r_rd_bank as seen before any same-cycle swap.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      if (!r_rd_bank) begin
        r_bank1[w_mem_idx] <= w_mem_wdata;
      end else begin
        r_bank0[w_mem_idx] <= w_mem_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_clr_ptr  <= '0;
      r_wr_cnt   <= '0;
      r_wr_full  <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_addr_err <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
          end else begin
            if (rd_en) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= w_rd_in ? w_rd_word : '0;
              if (!w_rd_in) begin
                r_addr_err <= 1'b1;
              end
            end
            if (wr_en && !w_wr_in) begin
              r_addr_err <= 1'b1;
            end
            // A swap restarts fill tracking for the new write bank, so it
            // takes precedence over counting a same-cycle write.
            if (swap) begin
              r_rd_bank <= ~r_rd_bank;
              r_wr_cnt  <= '0;
              r_wr_full <= 1'b0;
            end else if (w_wr_acc) begin
              if (r_wr_cnt != DEPTH_C) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
              end
              r_wr_full <= (r_wr_cnt >= LAST_CNT);
            end
          end
        end
        S_CLEAR: begin
          if (r_clr_ptr == LAST_IDX) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_wr_cnt   <= '0;
            r_wr_full  <= 1'b0;
            r_addr_err <= 1'b0;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign busy     = r_busy;
  assign wr_full  = r_wr_full;
  assign rd_bank  = r_rd_bank;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_nn_pingpong_buffer.sv
// Testbench for nn_pingpong_buffer: a table of single-cycle vectors for the
// read/write/swap behaviour plus hand-written sequences for fill tracking,
// the clear sequencer, and reset during clear.
module tb_nn_pingpong_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic                     swap;
  logic                     clear;
  logic                     busy;
  logic                     wr_full;
  logic                     rd_bank;
  logic                     addr_err;

  nn_pingpong_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .swap    (swap),
    .clear   (clear),
    .busy    (busy),
    .wr_full (wr_full),
    .rd_bank (rd_bank),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              swap;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
    logic              exp_bank;
    logic              exp_err;
  } vec_t;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  function automatic vec_t mkv(input logic we, input int wa, input logic [31:0] wd,
                               input logic re, input int ra, input logic sw,
                               input logic ev, input logic [31:0] ed,
                               input logic eb, input logic ee);
    vec_t v;
    v.wr_en = we;  v.wr_addr = ADDR_W'(wa); v.wr_data = wd;
    v.rd_en = re;  v.rd_addr = ADDR_W'(ra); v.swap = sw;
    v.exp_valid = ev; v.exp_data = ed; v.exp_bank = eb; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; swap = 1'b0; clear = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    step();
    swap = 1'b0;
  endtask

  task automatic do_read(input int a);
    rd_en = 1'b1; rd_addr = ADDR_W'(a);
    step();
    rd_en = 1'b0;
  endtask

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned busy_cycles;
    logic        saw_valid;
    logic        bank_moved;

    // Read bank is bank1 (100+addr) when the table starts; write bank is bank0.
    vecs[0]  = mkv(0,  0, 32'h0,        1,  5, 0, 1, 32'd105,      1, 0);
    vecs[1]  = mkv(0,  0, 32'h0,        0,  0, 0, 0, 32'd105,      1, 0);
    vecs[2]  = mkv(1, 40, 32'hDEAD,     0,  0, 0, 0, 32'd105,      1, 1);
    vecs[3]  = mkv(0,  0, 32'h0,        1, 40, 0, 1, 32'd0,        1, 1);
    vecs[4]  = mkv(0,  0, 32'h0,        1, 31, 0, 1, 32'd131,      1, 1);
    vecs[5]  = mkv(0,  0, 32'h0,        1,  0, 0, 1, 32'd100,      1, 1);
    vecs[6]  = mkv(0,  0, 32'h0,        1, 32, 0, 1, 32'd0,        1, 1);
    vecs[7]  = mkv(1,  3, 32'd7,        1,  3, 1, 1, 32'd103,      0, 1);
    vecs[8]  = mkv(0,  0, 32'h0,        1,  3, 0, 1, 32'd7,        0, 1);
    vecs[9]  = mkv(1,  1, 32'hFFFFFFFB, 0,  0, 0, 0, 32'd7,        0, 1);
    vecs[10] = mkv(0,  0, 32'h0,        0,  0, 1, 0, 32'd7,        1, 1);
    vecs[11] = mkv(0,  0, 32'h0,        1,  1, 0, 1, 32'hFFFFFFFB, 1, 1);
    vecs[12] = mkv(0,  0, 32'h0,        1,  2, 0, 1, 32'd102,      1, 1);
    vecs[13] = mkv(0,  0, 32'h0,        0,  0, 1, 0, 32'd102,      0, 1);
    vecs[14] = mkv(0,  0, 32'h0,        0,  0, 1, 0, 32'd102,      1, 1);
    vecs[15] = mkv(0,  0, 32'h0,        0,  0, 1, 0, 32'd102,      0, 1);

    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check("reset rd_data",  rd_data,  0);
    check("reset rd_valid", rd_valid, 0);
    check("reset busy",     busy,     0);
    check("reset wr_full",  wr_full,  0);
    check("reset rd_bank",  rd_bank,  0);
    check("reset addr_err", addr_err, 0);
    reset = 1'b0;
    step();

    // Fill bank1 with 100+addr; wr_full rises only after the 32nd write.
    for (int i = 0; i < DEPTH; i++) begin
      do_write(i, 32'(100 + i));
      if (i == DEPTH - 2) check("fill wr_full after 31", wr_full, 0);
    end
    check("fill wr_full after 32", wr_full, 1);
    do_swap();
    check("swap1 rd_bank", rd_bank, 1);
    check("swap1 wr_full", wr_full, 0);

    for (int i = 0; i < 16; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr; swap = vecs[i].swap;
      step();
      check($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d rd_data", i),  rd_data,  vecs[i].exp_data);
      check($sformatf("vec%0d rd_bank", i),  rd_bank,  vecs[i].exp_bank);
      check($sformatf("vec%0d addr_err", i), addr_err, vecs[i].exp_err);
      check($sformatf("vec%0d wr_full", i),  wr_full,  0);
      check($sformatf("vec%0d busy", i),     busy,     0);
    end
    idle_inputs();

    // Clear: write bank is bank1; fill it with all-ones first.
    for (int i = 0; i < DEPTH; i++) do_write(i, 32'hFFFFFFFF);
    check("prefill wr_full", wr_full, 1);
    clear = 1'b1; swap = 1'b1;
    wr_en = 1'b1; wr_addr = 16'd5; wr_data = 32'h12345678;
    rd_en = 1'b1; rd_addr = 16'd40;
    step();
    clear = 1'b0;
    check("clear start busy", busy, 1);
    busy_cycles = 0; saw_valid = 1'b0; bank_moved = 1'b0;
    for (int k = 0; k < 100 && busy; k++) begin
      busy_cycles++;
      if (rd_valid) saw_valid = 1'b1;
      if (rd_bank)  bank_moved = 1'b1;
      step();
    end
    idle_inputs();
    check("clear busy cycles",  busy_cycles, DEPTH);
    check("clear rd_valid seen", saw_valid,  0);
    check("clear rd_bank moved", bank_moved, 0);
    check("clear rd_bank",      rd_bank,     0);
    check("clear addr_err",     addr_err,    0);
    check("clear wr_full",      wr_full,     0);
    do_swap();
    check("post-clear rd_bank", rd_bank, 1);
    for (int i = 0; i < DEPTH; i++) begin
      do_read(i);
      check($sformatf("cleared rd_data[%0d]", i), rd_data, 0);
      if (i == 0) check("cleared rd_valid", rd_valid, 1);
    end
    check("post-clear addr_err", addr_err, 0);

    // Reset during clear: make every output non-reset first.
    do_write(2, 32'd55);
    do_swap();
    do_read(2);
    check("pre-abort rd_data", rd_data, 55);
    do_write(100, 32'd1);
    check("pre-abort addr_err", addr_err, 1);
    do_swap();
    check("pre-abort rd_bank", rd_bank, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 9; k++) step();
    check("abort busy before reset", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy",     busy,     0);
    check("abort rd_data",  rd_data,  0);
    check("abort rd_valid", rd_valid, 0);
    check("abort wr_full",  wr_full,  0);
    check("abort rd_bank",  rd_bank,  0);
    check("abort addr_err", addr_err, 0);
    step();
    check("abort busy stays 0", busy, 0);

    // Rewrites to one address still count toward wr_full; count saturates.
    for (int i = 0; i < DEPTH; i++) begin
      do_write(0, 32'(i));
      if (i == DEPTH - 2) check("rewrite wr_full after 31", wr_full, 0);
    end
    check("rewrite wr_full after 32", wr_full, 1);
    do_write(0, 32'd99);
    check("rewrite wr_full saturated", wr_full, 1);
    do_swap();
    check("rewrite swap wr_full", wr_full, 0);
    do_write(1, 32'd1);
    check("rewrite one after swap", wr_full, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nn_pingpong_buffer.md
Name: nn_pingpong_buffer

Overview:
Parametrised, double-buffered activation memory that sits between two matrix-multiply stages. The producer stage fills the write bank while the consumer stage reads the previous layer's results from the read bank. A single-cycle swap exchanges the two banks. The block adds a registered read with a valid strobe, a hardware bank-clear sequencer, fill tracking, and out-of-range detection.

Parameters:
DATA_W, 32, width of each signed word
DEPTH, 32, words per bank (1 to 2^ADDR_W)
ADDR_W, 16, width of the address ports

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write request into the write bank
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  signed write data
rd_en  in  1  read request from the read bank
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  signed registered read data
rd_valid  out  1  one-cycle strobe, rd_data updated this cycle
swap  in  1  exchange read and write banks
clear  in  1  start zeroing the write bank
busy  out  1  clear sequence in progress
wr_full  out  1  accepted-write count == DEPTH since last swap/clear
rd_bank  out  1  index of the current read bank; write bank = ~rd_bank
addr_err  out  1  sticky flag, an out-of-range access occurred

Behaviour:
- Storage: two banks of DEPTH x DATA_W. Memory contents are not reset.
- Reset values: rd_data=0, rd_valid=0, busy=0, wr_full=0, rd_bank=0, addr_err=0. The internal write count is 0 and the FSM is in IDLE.
- Priority within a cycle: reset > clear > {swap, write, read}.
- FSM states:
  - IDLE: on clear=1, go to CLEAR with the clear pointer at 0. busy=1 from the next cycle.
  - CLEAR: each cycle writes 0 to write bank [pointer] and increments the pointer. After writing address DEPTH-1, return to IDLE. busy is 1 for exactly DEPTH cycles.
  - On leaving CLEAR: write count=0, wr_full=0, addr_err=0.
- While busy: wr_en, rd_en, swap and clear are ignored, and rd_valid stays 0.
- Write (IDLE, wr_en=1):
  - If wr_addr < DEPTH, the write bank word is updated at the edge.
  - The write count increments and saturates at DEPTH. wr_full is registered and becomes 1 the cycle after the DEPTH-th accepted write.
  - If wr_addr >= DEPTH, no write occurs, the count is unchanged, and addr_err is set.
  - Rewriting the same address still counts, so wr_full means "DEPTH writes accepted", not "all addresses covered".
- Read (IDLE, rd_en=1): latency is one cycle.
  - The next cycle has rd_valid=1 and rd_data = read bank[rd_addr].
  - If rd_addr >= DEPTH: rd_data=0, rd_valid=1, and addr_err is set.
  - With rd_en=0, rd_valid=0 and rd_data holds its last value.
- Swap (IDLE, swap=1): rd_bank toggles at that edge, write count=0, wr_full=0.
  - A write or read issued in the same cycle as swap uses the pre-swap bank assignment.
  - Back-to-back swaps toggle every cycle.
- Concurrent read and write always target different banks. There is no collision case.
- Same cycle as clear: wr_en, rd_en and swap are dropped.
- addr_err is cleared only by reset or by completion of a clear.
- Reset mid-clear: abort immediately to IDLE with busy=0. Contents of the partially cleared bank are unspecified.

Test Plan:
- Reset, then write 0..31 into bank1 with data 100+addr, then swap. Required: rd_bank=1, and wr_full was 1 before the swap and 0 after it. Reading addr 5 gives rd_data=105 with rd_valid exactly one cycle after rd_en.
- Write addr 40 = 0xDEAD, then read addr 40. Required: no write, addr_err=1, and the read returns rd_data=0 with rd_valid=1. addr_err stays 1 until a clear completes.
- Same cycle: swap=1, wr_en to addr 3 with data 7, rd_en on addr 3. Required: the data lands in the pre-swap write bank and the read returns the pre-swap read bank. After the swap, reading addr 3 returns 7.
- Fill the write bank with 0xFFFFFFFF, then pulse clear. Required: busy=1 for exactly 32 cycles, and rd_en/wr_en during that window have no effect. After swap, every address reads 0 and addr_err=0.
- Assert reset at clear cycle 10. Required: busy=0 the next cycle, all outputs at reset values, and rd_bank=0.
- Assert clear and swap together. Required: clear runs and rd_bank is unchanged.
